// File: rtl/rtc_calendar_core_if.sv
// rtc_calendar_core_if: operator control pulses into the calendar core,
// calendar fields and display status back out.
interface rtc_calendar_core_if #(
   parameter int YEAR_W = 12
);
   logic              pause;
   logic              set_tgl;
   logic              field_nxt;
   logic              inc;
   logic              dec;
   logic [5:0]        sec;
   logic [5:0]        min;
   logic [4:0]        hour;
   logic [4:0]        day;
   logic [3:0]        month;
   logic [YEAR_W-1:0] year;
   logic [2:0]        sel_field;
   logic              set_mode;
   logic              blank;
   logic              sec_tick;

   modport master (
      output pause, set_tgl, field_nxt, inc, dec,
      input  sec, min, hour, day, month, year,
      input  sel_field, set_mode, blank, sec_tick
   );

   modport slave (
      input  pause, set_tgl, field_nxt, inc, dec,
      output sec, min, hour, day, month, year,
      output sel_field, set_mode, blank, sec_tick
   );
endinterface

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: sec..year calendar with Gregorian leap years and a
// RUN/SET editing FSM; prescaler divides clk down to one tick per second.
module rtc_calendar_core #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int YEAR_W    = 12,
   parameter int YEAR_INIT = 2000
) (
   input  logic               clk,
   input  logic               rst_n,
   rtc_calendar_core_if.slave bus
);

   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] P_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);

   typedef enum logic {
      S_RUN,
      S_SET
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic              phase_q, phase_d;
   logic              tick_q, tick_d;
   logic [2:0]        sel_q, sel_d;
   logic [5:0]        sec_q, sec_d;
   logic [5:0]        min_q, min_d;
   logic [4:0]        hour_q, hour_d;
   logic [4:0]        day_q, day_d;
   logic [3:0]        month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;

   logic              run;
   logic              adv;
   logic              wrap;
   logic [4:0]        dim_c;

   function automatic logic [4:0] dim_f(
      input logic [3:0]        m,
      input logic [YEAR_W-1:0] y
   );
      logic [31:0] yy;
      logic        leap;
      logic [4:0]  d;
      yy   = 32'(y);
      leap = ((yy % 32'd4) == 32'd0 && (yy % 32'd100) != 32'd0)
          || (yy % 32'd400) == 32'd0;
      unique case (m)
         4'd2:                      d = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
         default:                   d = 5'd31;
      endcase
      return d;
   endfunction

   // Wrapping step inside [lo,hi]; values already past hi wrap up to lo.
   function automatic logic [5:0] step_f(
      input logic [5:0] v,
      input logic [5:0] lo,
      input logic [5:0] hi,
      input logic       up
   );
      logic [5:0] r;
      if (up) r = (v >= hi) ? lo : v + 6'd1;
      else    r = (v <= lo) ? hi : v - 6'd1;
      return r;
   endfunction

   assign run   = (state_q == S_RUN);
   assign adv   = !run || !bus.pause;
   assign wrap  = (presc_q == P_MAX);
   assign dim_c = dim_f(month_q, year_q);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      sel_d   = sel_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      day_d   = day_q;
      month_d = month_q;
      year_d  = year_q;

      if (adv) begin
         presc_d = wrap ? '0 : presc_q + PW'(1);
         if (wrap || presc_q == P_HALF) phase_d = !phase_q;
      end

      unique case (1'b1)
         run && bus.set_tgl: begin
            state_d = S_SET;
            sel_d   = '0;
         end
         run && !bus.set_tgl && adv && wrap: begin
            tick_d = 1'b1;
            if (sec_q >= 6'd59) begin
               sec_d = '0;
               if (min_q >= 6'd59) begin
                  min_d = '0;
                  if (hour_q >= 5'd23) begin
                     hour_d = '0;
                     if (day_q >= dim_c) begin
                        day_d = 5'd1;
                        if (month_q >= 4'd12) begin
                           month_d = 4'd1;
                           year_d  = year_q + YEAR_W'(1);
                        end else begin
                           month_d = month_q + 4'd1;
                        end
                     end else begin
                        day_d = day_q + 5'd1;
                     end
                  end else begin
                     hour_d = hour_q + 5'd1;
                  end
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
         !run && bus.set_tgl: begin
            // Restart the second and the flash phase from a clean edge.
            state_d = S_RUN;
            presc_d = '0;
            phase_d = 1'b0;
            if (day_q > dim_c) day_d = dim_c;
         end
         !run && !bus.set_tgl: begin
            if (bus.field_nxt)
               sel_d = (sel_q >= 3'd5) ? 3'd0 : sel_q + 3'd1;
            if (bus.inc ^ bus.dec) begin
               unique case (sel_q)
                  3'd0: sec_d = step_f(sec_q, 6'd0, 6'd59, bus.inc);
                  3'd1: min_d = step_f(min_q, 6'd0, 6'd59, bus.inc);
                  3'd2: hour_d = 5'(step_f(6'(hour_q), 6'd0, 6'd23,
                                           bus.inc));
                  3'd3: day_d = 5'(step_f(6'(day_q), 6'd1, 6'(dim_c),
                                          bus.inc));
                  3'd4: month_d = 4'(step_f(6'(month_q), 6'd1, 6'd12,
                                            bus.inc));
                  3'd5: year_d = bus.inc ? year_q + YEAR_W'(1)
                                         : year_q - YEAR_W'(1);
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         presc_q <= '0;
         phase_q <= 1'b0;
         tick_q  <= 1'b0;
         sel_q   <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hour_q  <= '0;
         day_q   <= 5'd1;
         month_q <= 4'd1;
         year_q  <= YEAR_W'(YEAR_INIT);
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         tick_q  <= tick_d;
         sel_q   <= sel_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         day_q   <= day_d;
         month_q <= month_d;
         year_q  <= year_d;
      end
   end

   assign bus.sec       = sec_q;
   assign bus.min       = min_q;
   assign bus.hour      = hour_q;
   assign bus.day       = day_q;
   assign bus.month     = month_q;
   assign bus.year      = year_q;
   assign bus.sel_field = sel_q;
   assign bus.set_mode  = (state_q == S_SET);
   assign bus.blank     = (state_q == S_SET) & phase_q;
   assign bus.sec_tick  = tick_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core: scoreboard bench for the calendar core at CLK_HZ=4;
// expected values are queued as stimulus is driven and drained at negedge.
module tb_rtc_calendar_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rtc_calendar_core_if #(.YEAR_W(12)) bus ();

   rtc_calendar_core #(
      .CLK_HZ   (4),
      .YEAR_W   (12),
      .YEAR_INIT(2000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   string tq[$];
   int    vq[$];

   int m_sec, m_min, m_hour, m_day, m_month, m_year, m_sel;

   task automatic chk(input string tag, input int o, input int e);
      n_chk++;
      if (o !== e) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, o, e);
      end
   endtask

   function automatic int obs(input string t);
      case (t)
         "sec":   return int'(bus.sec);
         "min":   return int'(bus.min);
         "hour":  return int'(bus.hour);
         "day":   return int'(bus.day);
         "month": return int'(bus.month);
         "year":  return int'(bus.year);
         "sel":   return int'(bus.sel_field);
         "mode":  return int'(bus.set_mode);
         "blank": return int'(bus.blank);
         "tick":  return int'(bus.sec_tick);
         default: return -1;
      endcase
   endfunction

   task automatic push(input string t, input int v);
      tq.push_back(t);
      vq.push_back(v);
   endtask

   task automatic drain();
      string t;
      int    v;
      while (tq.size() > 0) begin
         t = tq.pop_front();
         v = vq.pop_front();
         chk(t, obs(t), v);
      end
   endtask

   task automatic exp_time(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
      push("year", y);
      push("month", mo);
      push("day", d);
      push("hour", h);
      push("min", mi);
      push("sec", s);
   endtask

   task automatic exp_reset();
      exp_time(2000, 1, 1, 0, 0, 0);
      push("sel", 0);
      push("mode", 0);
      push("blank", 0);
      push("tick", 0);
   endtask

   function automatic int b_dim(input int mo, input int y);
      bit lp;
      lp = (y % 400 == 0) || (y % 4 == 0 && y % 100 != 0);
      case (mo)
         2:            return lp ? 29 : 28;
         4, 6, 9, 11:  return 30;
         default:      return 31;
      endcase
   endfunction

   function automatic int get_m(input int f);
      case (f)
         0:       return m_sec;
         1:       return m_min;
         2:       return m_hour;
         3:       return m_day;
         4:       return m_month;
         default: return m_year;
      endcase
   endfunction

   task automatic set_m(input int f, input int v);
      case (f)
         0:       m_sec = v;
         1:       m_min = v;
         2:       m_hour = v;
         3:       m_day = v;
         4:       m_month = v;
         default: m_year = v;
      endcase
   endtask

   task automatic pulse(input bit t, input bit n, input bit i, input bit d);
      bus.set_tgl   = t;
      bus.field_nxt = n;
      bus.inc       = i;
      bus.dec       = d;
      @(negedge clk);
      bus.set_tgl   = 1'b0;
      bus.field_nxt = 1'b0;
      bus.inc       = 1'b0;
      bus.dec       = 1'b0;
   endtask

   task automatic do_reset();
      bus.pause = 1'b0;
      bus.set_tgl = 1'b0;
      bus.field_nxt = 1'b0;
      bus.inc = 1'b0;
      bus.dec = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_sec = 0; m_min = 0; m_hour = 0;
      m_day = 1; m_month = 1; m_year = 2000; m_sel = 0;
      exp_reset();
      drain();
   endtask

   task automatic enter_set();
      pulse(1, 0, 0, 0);
      m_sel = 0;
      push("mode", 1);
      push("sel", 0);
      push("tick", 0);
      drain();
   endtask

   task automatic goto_sel(input int f);
      while (m_sel != f) begin
         pulse(0, 1, 0, 0);
         m_sel = (m_sel + 1) % 6;
      end
   endtask

   task automatic edit_to(input int f, input int tgt);
      int lo, hi, rng, up, cur;
      goto_sel(f);
      cur = get_m(f);
      lo = (f == 3 || f == 4) ? 1 : 0;
      case (f)
         0, 1:    hi = 59;
         2:       hi = 23;
         3:       hi = b_dim(m_month, m_year);
         4:       hi = 12;
         default: hi = 4095;
      endcase
      rng = hi - lo + 1;
      up  = (tgt - cur + rng) % rng;
      if (up <= rng - up) repeat (up) pulse(0, 0, 1, 0);
      else                repeat (rng - up) pulse(0, 0, 0, 1);
      set_m(f, tgt);
   endtask

   task automatic prog(input int y, input int mo, input int d,
                       input int h, input int mi, input int s);
      edit_to(4, mo);
      edit_to(5, y);
      edit_to(0, s);
      edit_to(1, mi);
      edit_to(2, h);
      edit_to(3, d);
      exp_time(y, mo, d, h, mi, s);
      push("sel", 3);
      push("mode", 1);
      drain();
   endtask

   task automatic run_case(input int y, input int mo, input int d,
                           input int ny, input int nmo, input int nd);
      do_reset();
      enter_set();
      prog(y, mo, d, 23, 59, 59);
      pulse(1, 0, 0, 0);
      push("mode", 0);
      push("tick", 0);
      drain();
      repeat (3) @(negedge clk);
      exp_time(y, mo, d, 23, 59, 59);
      push("tick", 0);
      drain();
      @(negedge clk);
      exp_time(ny, nmo, nd, 0, 0, 0);
      push("tick", 1);
      drain();
      @(negedge clk);
      push("tick", 0);
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      bus.pause = 1'b0;
      bus.set_tgl = 1'b0;
      bus.field_nxt = 1'b0;
      bus.inc = 1'b0;
      bus.dec = 1'b0;

      // Rollover and leap-year carries
      run_case(2023, 12, 31, 2024, 1, 1);
      run_case(2024, 2, 28, 2024, 2, 29);
      run_case(2100, 2, 28, 2100, 3, 1);
      run_case(2000, 2, 29, 2000, 3, 1);

      // Flash phase in SET, then day clamp on exit
      do_reset();
      enter_set();
      for (int k = 0; k < 6; k++) begin
         push("blank", ((k + 1) >> 1) & 1);
         drain();
         @(negedge clk);
      end
      prog(2023, 1, 31, 0, 0, 0);
      goto_sel(4);
      pulse(0, 0, 1, 0);
      push("month", 2);
      push("day", 31);
      push("sel", 4);
      drain();
      pulse(1, 0, 0, 0);
      push("mode", 0);
      push("month", 2);
      push("day", 28);
      push("blank", 0);
      drain();

      // Edit wrap, no borrow, simultaneous pulses
      do_reset();
      enter_set();
      prog(2023, 6, 1, 10, 0, 0);
      goto_sel(1);
      pulse(0, 0, 0, 1);
      push("min", 59);
      push("hour", 10);
      drain();
      pulse(0, 0, 1, 1);
      push("min", 59);
      drain();
      pulse(0, 1, 1, 0);
      m_sel = 2;
      push("min", 0);
      push("hour", 10);
      push("sel", 2);
      drain();
      goto_sel(3);
      pulse(0, 0, 0, 1);
      push("day", 30);
      push("month", 6);
      drain();
      pulse(1, 0, 1, 0);
      push("mode", 0);
      push("day", 30);
      push("hour", 10);
      drain();
      pulse(0, 1, 1, 0);
      push("sel", 3);
      push("day", 30);
      push("sec", 0);
      drain();
      pulse(0, 0, 0, 1);
      push("day", 30);
      push("tick", 0);
      drain();

      // Pause holds the prescaler at 2
      do_reset();
      repeat (2) @(negedge clk);
      bus.pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         push("sec", 0);
         push("tick", 0);
         drain();
      end
      bus.pause = 1'b0;
      @(negedge clk);
      push("sec", 0);
      push("tick", 0);
      drain();
      @(negedge clk);
      push("sec", 1);
      push("tick", 1);
      drain();

      // Asynchronous reset while editing
      do_reset();
      enter_set();
      edit_to(5, 2003);
      push("year", 2003);
      push("mode", 1);
      push("sel", 5);
      drain();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_reset();
      drain();
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
